// File: rtl/game_controller_if.sv
// Player/datapath signal bundle for game_controller.
// master = stimulus side (drives inputs), slave = the controller.
interface game_controller_if #(
    parameter int SCORE_W = 10
);
    logic               en;
    logic [1:0]         buttons;
    logic [1:0]         level_switch;
    logic               frame_tick;
    logic               paddle_hit;
    logic               ball_miss;
    logic [2:0]         state;
    logic               ball_reset;
    logic               ball_run;
    logic [2:0]         speed_h;
    logic [1:0]         speed_v;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    modport master (
        output en, buttons, level_switch, frame_tick, paddle_hit, ball_miss,
        input  state, ball_reset, ball_run, speed_h, speed_v, lives, score, high_score
    );

    modport slave (
        input  en, buttons, level_switch, frame_tick, paddle_hit, ball_miss,
        output state, ball_reset, ball_run, speed_h, speed_v, lives, score, high_score
    );
endinterface

// File: rtl/game_controller.sv
// Pong game-flow sequencer: serve/play/miss/game-over, lives, score, high score, ball speed.
// Define PAUSE_EN to add the two-button PAUSE state.
module game_controller #(
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 10,
    parameter int SERVE_FRAMES  = 60,
    parameter int MISS_FRAMES   = 30,
    parameter int HITS_PER_STEP = 5
) (
    input  logic clk_50MHz,
    input  logic arst_n,
    game_controller_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_MISS      = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;
`ifdef PAUSE_EN
    localparam logic [2:0] S_PAUSE     = 3'd5;
`endif

    localparam int MAXF = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int FW   = (MAXF > 2) ? $clog2(MAXF) : 1;
    localparam int HW   = (HITS_PER_STEP > 2) ? $clog2(HITS_PER_STEP) : 1;
    localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
    localparam logic [FW-1:0] MISS_LAST  = FW'(MISS_FRAMES - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_STEP - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [2:0]         step_q, step_d;
    logic [HW-1:0]      hit_cnt_q, hit_cnt_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [1:0]         btn_q;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               ball_reset_q, ball_reset_d;
    logic               ball_run_q, ball_run_d;
    logic [2:0]         speed_h_q, speed_h_d;
    logic [1:0]         speed_v_q, speed_v_d;

    logic [1:0] rise;
    logic       press;
    assign rise  = bus.buttons & ~btn_q;
    assign press = |rise;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        step_d      = step_q;
        hit_cnt_d   = hit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;
        score_d     = score_q;
        high_d      = high_q;

        case (state_q)
            S_IDLE: begin
                if (press) begin
                    level_d     = bus.level_switch;
                    lives_d     = 2'(LIVES);
                    score_d     = '0;
                    step_d      = '0;
                    hit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    state_d     = S_SERVE;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = S_PLAY;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
`ifdef PAUSE_EN
                if (&rise) state_d = S_PAUSE;
                else
`endif
                if (bus.ball_miss) begin
                    // Miss takes priority over a coincident hit.
                    lives_d     = lives_q - 2'd1;
                    frame_cnt_d = '0;
                    state_d     = S_MISS;
                end else if (bus.paddle_hit) begin
                    if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
                    if (hit_cnt_q == HIT_LAST) begin
                        hit_cnt_d = '0;
                        if (step_q < 3'd4) step_d = step_q + 3'd1;
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
            end
            S_MISS: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == MISS_LAST) begin
                        frame_cnt_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = S_GAME_OVER;
                            if (score_q > high_q) high_d = score_q;
                        end else begin
                            state_d = S_SERVE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_GAME_OVER: begin
                if (press) state_d = S_IDLE;
            end
`ifdef PAUSE_EN
            S_PAUSE: begin
                if (&rise) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        ball_reset_d = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_GAME_OVER);
        ball_run_d   = (state_d == S_PLAY);

        // Speeds follow the next-state level/step so they land with the state change.
        case (level_d)
            2'b00:   begin speed_h_d = 3'd1; speed_v_d = 2'd1; end
            2'b01:   begin speed_h_d = 3'd3; speed_v_d = 2'd2; end
            2'b10:   begin speed_h_d = 3'd5; speed_v_d = 2'd3; end
            default: begin
                speed_h_d = step_d + 3'd1;
                case (step_d)
                    3'd0, 3'd1: speed_v_d = 2'd1;
                    3'd2, 3'd3: speed_v_d = 2'd2;
                    default:    speed_v_d = 2'd3;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            level_q      <= 2'b00;
            step_q       <= '0;
            hit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            btn_q        <= 2'b00;
            lives_q      <= 2'(LIVES);
            score_q      <= '0;
            high_q       <= '0;
            ball_reset_q <= 1'b1;
            ball_run_q   <= 1'b0;
            speed_h_q    <= 3'd1;
            speed_v_q    <= 2'd1;
        end else if (bus.en) begin
            state_q      <= state_d;
            level_q      <= level_d;
            step_q       <= step_d;
            hit_cnt_q    <= hit_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            btn_q        <= bus.buttons;
            lives_q      <= lives_d;
            score_q      <= score_d;
            high_q       <= high_d;
            ball_reset_q <= ball_reset_d;
            ball_run_q   <= ball_run_d;
            speed_h_q    <= speed_h_d;
            speed_v_q    <= speed_v_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.ball_run   = ball_run_q;
    assign bus.speed_h    = speed_h_q;
    assign bus.speed_v    = speed_v_q;
    assign bus.lives      = lives_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
endmodule

// File: tb/tb_game_controller.sv
// Directed game flows with randomized hit counts, gaps and ignored pulses,
// checked against a score/lives/hit-total model of the game rules.
module tb_game_controller;
    logic clk_50MHz = 1'b0;
    logic arst_n    = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    game_controller_if #(.SCORE_W(10)) bus();

    game_controller dut (
        .clk_50MHz (clk_50MHz),
        .arst_n    (arst_n),
        .bus       (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int m_score, m_lives, m_high, m_hits, m_level;

    function automatic int m_step();
        return (m_hits / 5 > 4) ? 4 : m_hits / 5;
    endfunction

    function automatic int exp_h();
        return (m_level < 3) ? 2 * m_level + 1 : m_step() + 1;
    endfunction

    function automatic int exp_v();
        return (m_level < 3) ? m_level + 1 : m_step() / 2 + 1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: drive inputs, then sample 1 time unit after the edge.
    task automatic cyc(input bit ft, input bit ph, input bit bm, input logic [1:0] bt);
        bus.frame_tick = ft;
        bus.paddle_hit = ph;
        bus.ball_miss  = bm;
        bus.buttons    = bt;
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(bus.state), 0);
        check({tag, "_ball_reset"}, int'(bus.ball_reset), 1);
        check({tag, "_ball_run"}, int'(bus.ball_run), 0);
        check({tag, "_speed_h"}, int'(bus.speed_h), 1);
        check({tag, "_speed_v"}, int'(bus.speed_v), 1);
        check({tag, "_lives"}, int'(bus.lives), 3);
        check({tag, "_score"}, int'(bus.score), 0);
        check({tag, "_high"}, int'(bus.high_score), 0);
    endtask

    task automatic start_game(input int lvl);
        logic [1:0] lv;
        lv = 2'(lvl);
        bus.level_switch = lv;
        cyc(1'b1, 1'b0, 1'b0, 2'b01);
        m_level = lvl; m_score = 0; m_lives = 3; m_hits = 0;
        check("start_state", int'(bus.state), 1);
        check("start_lives", int'(bus.lives), 3);
        check("start_score", int'(bus.score), 0);
        check("start_ball_reset", int'(bus.ball_reset), 1);
        check("start_speed_h", int'(bus.speed_h), exp_h());
        check("start_speed_v", int'(bus.speed_v), exp_v());
        bus.level_switch = 2'($urandom);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic serve_to_play();
        repeat (59) cyc(1'b1, 1'($urandom), 1'($urandom), 2'b00);
        check("serve_hold_state", int'(bus.state), 1);
        check("serve_hold_score", int'(bus.score), m_score);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("play_state", int'(bus.state), 2);
        check("play_ball_run", int'(bus.ball_run), 1);
        check("play_ball_reset", int'(bus.ball_reset), 0);
    endtask

    task automatic play_ball(input int nhits, input bit combo);
        for (int i = 0; i < nhits; i++) begin
            cyc(1'($urandom), 1'b1, 1'b0, 2'b00);
            m_hits++;
            m_score = (m_score < 1023) ? m_score + 1 : 1023;
            check("hit_score", int'(bus.score), m_score);
            check("hit_speed_h", int'(bus.speed_h), exp_h());
            check("hit_speed_v", int'(bus.speed_v), exp_v());
            repeat ($urandom_range(0, 2)) cyc(1'($urandom), 1'b0, 1'b0, 2'b00);
        end
        cyc(1'b1, combo, 1'b1, 2'b00);
        m_lives--;
        check("miss_state", int'(bus.state), 3);
        check("miss_lives", int'(bus.lives), m_lives);
        check("miss_score", int'(bus.score), m_score);
        check("miss_ball_run", int'(bus.ball_run), 0);
        check("miss_ball_reset", int'(bus.ball_reset), 0);
        repeat (29) cyc(1'b1, 1'($urandom), 1'($urandom), 2'b00);
        check("miss_hold_state", int'(bus.state), 3);
        check("miss_hold_lives", int'(bus.lives), m_lives);
        check("miss_hold_score", int'(bus.score), m_score);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        if (m_lives == 0) begin
            if (m_score > m_high) m_high = m_score;
            check("gameover_state", int'(bus.state), 4);
            check("gameover_high", int'(bus.high_score), m_high);
            check("gameover_ball_reset", int'(bus.ball_reset), 1);
        end else begin
            check("reserve_state", int'(bus.state), 1);
            check("reserve_ball_reset", int'(bus.ball_reset), 1);
        end
    endtask

    task automatic end_game();
        cyc(1'b0, 1'b0, 1'b0, 2'b10);
        check("idle_state", int'(bus.state), 0);
        check("idle_high", int'(bus.high_score), m_high);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.level_switch = 2'b00;
        bus.buttons = 2'b00;
        bus.frame_tick = 1'b0;
        bus.paddle_hit = 1'b0;
        bus.ball_miss = 1'b0;
        m_high = 0;

        arst_n = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        check_reset_values("reset");
        arst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 2'b00);
        check("idle_after_reset", int'(bus.state), 0);

        // Game 1: Hard, frozen cycle during SERVE, coincident hit+miss.
        start_game(2);
        bus.en = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        check("en_low_state", int'(bus.state), 1);
        bus.en = 1'b1;
        serve_to_play();
        play_ball(3, 1'b0);
        serve_to_play();
`ifdef PAUSE_EN
        cyc(1'b0, 1'b0, 1'b0, 2'b11);
        check("pause_state", int'(bus.state), 5);
        check("pause_ball_run", int'(bus.ball_run), 0);
        check("pause_ball_reset", int'(bus.ball_reset), 0);
        cyc(1'b1, 1'b1, 1'b1, 2'b00);
        check("pause_ignore_state", int'(bus.state), 5);
        check("pause_ignore_score", int'(bus.score), m_score);
        cyc(1'b0, 1'b0, 1'b0, 2'b11);
        check("unpause_state", int'(bus.state), 2);
        check("unpause_score", int'(bus.score), m_score);
        check("unpause_ball_run", int'(bus.ball_run), 1);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
`else
        cyc(1'b0, 1'b0, 1'b0, 2'b11);
        check("dual_press_state", int'(bus.state), 2);
        check("dual_press_ball_run", int'(bus.ball_run), 1);
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
`endif
        play_ball($urandom_range(1, 6), 1'b1);
        serve_to_play();
        play_ball($urandom_range(0, 6), 1'b0);
        end_game();

        // Game 2: Adaptive, long rally to saturate the step.
        start_game(3);
        serve_to_play();
        play_ball(22, 1'b0);
        serve_to_play();
        play_ball(1, 1'b1);
        serve_to_play();
        play_ball($urandom_range(0, 3), 1'b0);
        end_game();

        // Game 3: low score, high score must persist.
        start_game($urandom_range(0, 1));
        for (int b = 0; b < 3; b++) begin
            serve_to_play();
            play_ball($urandom_range(0, 2), 1'($urandom));
        end
        end_game();

        // Game 4: reset in the middle of play.
        start_game($urandom_range(0, 3));
        serve_to_play();
        play_ball(2, 1'b0);
        serve_to_play();
        cyc(1'b0, 1'b1, 1'b0, 2'b00);
        arst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 2'b00);
        check_reset_values("midplay_reset");
        arst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Game-flow sequencer for the single-player Pong arcade design.
- Sits between player inputs and the pixel-generation datapath. Decides when the ball is held, served or running.
- Tracks lives, score and high score.
- Drives the per-frame ball speed from the difficulty switches, including the adaptive level.
- Runs on the 50 MHz system clock. Events are qualified by a one-cycle frame tick.

Parameters:
- LIVES, 3: balls per game.
- SCORE_W, 10: width of score and high_score; saturating.
- SERVE_FRAMES, 60: frame ticks the ball is held at centre before launch.
- MISS_FRAMES, 30: frame ticks of pause after a miss.
- HITS_PER_STEP, 5: paddle hits per adaptive speed step.

Ports:
- clk_50MHz, input, 1: system clock.
- arst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: global enable; when low, all registers hold.
- buttons, input, 2: paddle buttons, already synchronous to clk_50MHz.
- level_switch, input, 2: 00 Easy, 01 Medium, 10 Hard, 11 Adaptive.
- frame_tick, input, 1: one-cycle pulse per video frame, at vsync start.
- paddle_hit, input, 1: one-cycle pulse when ball bounces off the paddle.
- ball_miss, input, 1: one-cycle pulse when ball passes the paddle.
- state, output, 3: 0 IDLE, 1 SERVE, 2 PLAY, 3 MISS, 4 GAME_OVER, 5 PAUSE.
- ball_reset, output, 1: datapath holds ball at centre.
- ball_run, output, 1: datapath moves ball this frame.
- speed_h, output, 3: horizontal px/frame.
- speed_v, output, 2: vertical px/frame.
- lives, output, 2: remaining balls.
- score, output, SCORE_W: current score.
- high_score, output, SCORE_W: best score since reset.

Behaviour:
- Reset values (arst_n low at a clk edge):
  - state=IDLE, ball_reset=1, ball_run=0, speed_h=1, speed_v=1.
  - lives=LIVES, score=0, high_score=0.
  - Adaptive step=0, hit counter=0, frame counter=0, button history=00.
- A reset asserted mid-game overrides everything on that edge. high_score is cleared only by reset.
- All outputs are registered. Each response appears one cycle after its causing event.
- While en=0, nothing updates, including edge history and counters.
- Press = rising edge of either buttons bit versus its previous-cycle value.
- IDLE:
  - ball_reset=1, ball_run=0.
  - On press: latch level_switch into level_q; lives=LIVES, score=0, step=0, hit count=0, frame counter=0; go to SERVE.
- SERVE:
  - ball_reset=1, ball_run=0. Count frame_tick.
  - On the SERVE_FRAMES-th tick: counter=0, go to PLAY.
- PLAY:
  - ball_reset=0, ball_run=1.
  - paddle_hit: score+1, saturating at 2^SCORE_W-1. Hit count+1; when it reaches HITS_PER_STEP, it clears and step+1, saturating at 4.
  - ball_miss: lives-1, frame counter=0, go to MISS.
  - paddle_hit and ball_miss in the same cycle: the miss wins and the score is unchanged.
- MISS:
  - ball_reset=0, ball_run=0. Count frame_tick.
  - On the MISS_FRAMES-th tick: go to GAME_OVER if lives==0, else to SERVE.
- GAME_OVER:
  - ball_reset=1, ball_run=0.
  - On entry, high_score<=score if score>high_score, else unchanged.
  - On press: go to IDLE.
- Speed mapping, from level_q, registered:
  - Easy: 1/1. Medium: 3/2. Hard: 5/3.
  - Adaptive, step 0..4: 1/1, 2/1, 3/2, 4/2, 5/3.
- level_switch changes mid-game are ignored until the next IDLE press.
- pulse inputs are ignored outside PLAY.
- A frame_tick arriving in the same cycle as a state entry is not counted.

Optional Feature:
- Macro: PAUSE_EN.
- Defined:
  - Both buttons rising together in PLAY go to PAUSE. PAUSE drives ball_run=0 and ball_reset=0 and freezes all counters.
  - Both rising together in PAUSE return to PLAY.
  - Pulses are ignored in PAUSE.
- Not defined:
  - The PAUSE state is absent. A simultaneous press in PLAY has no effect.
  - state encoding 5 is never produced.

Test Plan:
- Reset, then press buttons=01 with level_switch=10 -> SERVE next cycle; lives=3, score=0; speed_h=5, speed_v=3. After 60 frame_ticks -> PLAY with ball_run=1.
- PLAY, 3 paddle_hit pulses, then ball_miss -> score=3, lives=2, state MISS. After 30 ticks -> SERVE.
- Three misses with score=7, prior high_score=4 -> GAME_OVER, high_score=7. Next game ends with score=2 -> high_score stays 7.
- level_switch=11, 10 hits -> speed goes 1/1, then 2/1 after hit 5, then 3/2 after hit 10. At 20+ hits it stays 5/3.
- paddle_hit and ball_miss in the same cycle -> score unchanged, lives-1. en=0 during a frame_tick -> SERVE count not advanced. Reset mid-PLAY -> all reset values including high_score=0.
- With PAUSE_EN: simultaneous press in PLAY -> PAUSE, ball_run=0; hit pulses ignored; second simultaneous press -> PLAY with score unchanged.
